// File: rtl/rect_stream_dma.sv
// rect_stream_dma
// Walks a table of 6-word rectangle records in data memory and streams, pass
// by pass, the clamped LEFT, RIGHT, TOP and BOTTOM edges followed by the raw
// colours to the GPU rectangle loader. Relative coordinates resolve against a
// per-pass cursor. Beats leave on a valid/ready stream; after every
// BATCH_SIZE beats the block waits for the GPU's batch-done pulse.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   copy_start      : one-cycle start pulse, ignored unless idle
//   mem_din_addr    : data-memory read address (data returns next cycle)
//   mem_din         : data-memory read data
//   out_data        : clamped edge (zero-extended) or raw colour
//   out_field       : 0=LEFT 1=RIGHT 2=TOP 3=BOTTOM 4=COLOR
//   out_valid/ready : beat handshake
//   out_last        : beat closes a batch
//   gpu_batch_done  : GPU finished the current batch (only honoured while waiting)
//   busy            : frame in progress
//   done            : one-cycle pulse when the frame is complete
module rect_stream_dma #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RECT_ADDR  = ADDR_WIDTH'(256),
  parameter int                    RECT_COUNT = 64,
  parameter int                    BATCH_SIZE = 16,
  parameter int                    SCREEN_W   = 640,
  parameter int                    SCREEN_H   = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  copy_start,
  output logic [ADDR_WIDTH-1:0] mem_din_addr,
  input  logic [15:0]           mem_din,
  output logic [15:0]           out_data,
  output logic [2:0]            out_field,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  input  logic                  gpu_batch_done,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
  localparam int BAT_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECT_COUNT - 1);
  localparam logic [BAT_W-1:0] LAST_BAT = BAT_W'(BATCH_SIZE - 1);
  localparam logic [15:0]      LIM_X    = 16'(SCREEN_W);
  localparam logic [15:0]      LIM_Y    = 16'(SCREEN_H);

  localparam logic [2:0] P_RIGHT  = 3'd1;
  localparam logic [2:0] P_TOP    = 3'd2;
  localparam logic [2:0] P_BOTTOM = 3'd3;
  localparam logic [2:0] P_COLOR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_FLAG, S_RD_COORD, S_RD_SIZE, S_CALC, S_EMIT, S_WAIT_GPU
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            pass_q, pass_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BAT_W-1:0]      bat_q, bat_d;
  logic [ADDR_WIDTH-1:0] rec_addr_q, rec_addr_d;   // base of the current record
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  abs_q, abs_d;
  logic [15:0]           cursor_q, cursor_d;
  logic [15:0]           base_q, base_d;
  logic [15:0]           data_q, data_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;

  // Signed view: negative -> 0, at/above limit -> limit. The limit is below
  // 0x8000, so once the sign bit is clear an unsigned compare is exact.
  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
    if (v[15])         return 16'd0;
    else if (v >= lim) return lim;
    else               return v;
  endfunction

  logic                  is_y, has_size, is_color;
  logic [15:0]           limit, base_now, edge_val;
  logic [ADDR_WIDTH-1:0] first_off, coord_off, size_off;

  always_comb begin
    is_y      = (pass_q == P_TOP) || (pass_q == P_BOTTOM);
    has_size  = (pass_q == P_RIGHT) || (pass_q == P_BOTTOM);
    is_color  = (pass_q == P_COLOR);
    limit     = is_y ? LIM_Y : LIM_X;
    // mem_din holds the coordinate word whenever base_now is consumed
    base_now  = abs_q ? mem_din : 16'(cursor_q + mem_din);
    edge_val  = has_size ? 16'(base_q + mem_din) : base_now;
    first_off = is_color ? ADDR_WIDTH'(5) : ADDR_WIDTH'(0);
    coord_off = is_y ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
    size_off  = is_y ? ADDR_WIDTH'(4) : ADDR_WIDTH'(3);
  end

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    idx_d      = idx_q;
    bat_d      = bat_q;
    rec_addr_d = rec_addr_q;
    addr_d     = addr_q;
    abs_d      = abs_q;
    cursor_d   = cursor_q;
    base_d     = base_q;
    data_d     = data_q;
    last_d     = last_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // the cycle that pulses done is already IDLE; a start then is dropped
        if (copy_start && !done_q) begin
          state_d    = S_RD_FLAG;
          pass_d     = '0;
          idx_d      = '0;
          bat_d      = '0;
          rec_addr_d = RECT_ADDR;
          addr_d     = RECT_ADDR;
          cursor_d   = '0;
        end
      end
      S_RD_FLAG: begin
        // COLOR already presented word +5 here and needs no flag
        if (is_color) begin
          state_d = S_CALC;
        end else begin
          state_d = S_RD_COORD;
          addr_d  = rec_addr_q + coord_off;
        end
      end
      S_RD_COORD: begin
        abs_d = mem_din[0];
        if (has_size) begin
          state_d = S_RD_SIZE;
          addr_d  = rec_addr_q + size_off;
        end else begin
          state_d = S_CALC;
        end
      end
      S_RD_SIZE: begin
        base_d = base_now;
        if (abs_q) cursor_d = mem_din;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (is_color) begin
          data_d = mem_din;
        end else begin
          data_d = clamp(edge_val, limit);
          if (!has_size && abs_q) cursor_d = mem_din;
        end
        last_d  = (bat_q == LAST_BAT);
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            rec_addr_d = RECT_ADDR;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            rec_addr_d = rec_addr_q + ADDR_WIDTH'(6);
          end
          bat_d = last_q ? '0 : bat_q + BAT_W'(1);
          if (last_q) begin
            state_d = S_WAIT_GPU;
          end else begin
            state_d = S_RD_FLAG;
            addr_d  = rec_addr_q + ADDR_WIDTH'(6) + first_off;
          end
        end
      end
      S_WAIT_GPU: begin
        if (gpu_batch_done) begin
          // idx back at 0 means the batch just finished closed the pass
          if (idx_q != '0) begin
            state_d = S_RD_FLAG;
            addr_d  = rec_addr_q + first_off;
          end else if (is_color) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            addr_d  = RECT_ADDR;
          end else begin
            state_d  = S_RD_FLAG;
            pass_d   = pass_q + 3'd1;
            cursor_d = '0;
            addr_d   = RECT_ADDR + ((pass_q == P_BOTTOM) ? ADDR_WIDTH'(5) : ADDR_WIDTH'(0));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pass_q     <= '0;
      idx_q      <= '0;
      bat_q      <= '0;
      rec_addr_q <= RECT_ADDR;
      addr_q     <= RECT_ADDR;
      abs_q      <= 1'b0;
      cursor_q   <= '0;
      base_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      idx_q      <= idx_d;
      bat_q      <= bat_d;
      rec_addr_q <= rec_addr_d;
      addr_q     <= addr_d;
      abs_q      <= abs_d;
      cursor_q   <= cursor_d;
      base_q     <= base_d;
      data_q     <= data_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign mem_din_addr = addr_q;
  assign out_data     = data_q;
  assign out_field    = pass_q;
  assign out_last     = last_q;
  assign out_valid    = (state_q == S_EMIT);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_rect_stream_dma.sv
module tb_rect_stream_dma;

  localparam int         AW = 12;
  localparam logic [11:0] RA = 12'h100;
  localparam int         RC = 4;
  localparam int         BS = 2;
  localparam int         SW = 640;
  localparam int         SH = 480;

  logic          clk = 1'b0;
  logic          reset, copy_start, out_ready, gpu_batch_done;
  logic          out_valid, out_last, busy, done;
  logic [AW-1:0] mem_din_addr;
  logic [15:0]   mem_din, out_data;
  logic [2:0]    out_field;

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  always @(posedge clk) mem_din <= mem[mem_din_addr];

  rect_stream_dma #(
    .ADDR_WIDTH(AW), .RECT_ADDR(RA), .RECT_COUNT(RC), .BATCH_SIZE(BS),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .reset(reset), .copy_start(copy_start),
    .mem_din_addr(mem_din_addr), .mem_din(mem_din),
    .out_data(out_data), .out_field(out_field), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .gpu_batch_done(gpu_batch_done), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [15:0] flags, x, y, w, h, col;
  } rect_t;
  typedef struct packed {
    rect_t       r;
    logic [15:0] l, rt, t, b;
  } row_t;
  typedef struct packed {
    logic [2:0]  field;
    logic [15:0] data;
    logic        last;
  } beat_t;

  row_t  tbl [3*RC];
  rect_t cur [RC];
  beat_t exp_q [$];
  int    total = 0;
  int    bad   = 0;

  function automatic rect_t mk(input logic [15:0] fl, x, y, w, h, c);
    rect_t r;
    r.flags = fl; r.x = x; r.y = y; r.w = w; r.h = h; r.col = c;
    return r;
  endfunction

  function automatic row_t mkrow(input rect_t r, input logic [15:0] l, rt, t, b);
    row_t o;
    o.r = r; o.l = l; o.rt = rt; o.t = t; o.b = b;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // signed clamp against the screen limit
  function automatic logic [15:0] tclamp(input logic [15:0] v, input int lim);
    if (v[15]) return 16'd0;
    if (int'(v) >= lim) return 16'(lim);
    return v;
  endfunction

  task automatic load_mem();
    for (int i = 0; i < RC; i++) begin
      mem[int'(RA) + 6*i + 0] = cur[i].flags;
      mem[int'(RA) + 6*i + 1] = cur[i].x;
      mem[int'(RA) + 6*i + 2] = cur[i].y;
      mem[int'(RA) + 6*i + 3] = cur[i].w;
      mem[int'(RA) + 6*i + 4] = cur[i].h;
      mem[int'(RA) + 6*i + 5] = cur[i].col;
    end
  endtask

  // Reference: the whole frame as a list of beats, pass by pass.
  task automatic build_model();
    logic [15:0] cursor, c, s, v;
    beat_t bt;
    exp_q.delete();
    for (int p = 0; p < 5; p++) begin
      cursor = 16'd0;
      for (int i = 0; i < RC; i++) begin
        bt.field = 3'(p);
        bt.last  = ((i % BS) == BS - 1);
        if (p == 4) begin
          bt.data = cur[i].col;
        end else begin
          c = (p < 2) ? cur[i].x : cur[i].y;
          s = (p < 2) ? cur[i].w : cur[i].h;
          v = cur[i].flags[0] ? c : 16'(cursor + c);
          if (cur[i].flags[0]) cursor = c;
          if (p == 1 || p == 3) v = 16'(v + s);
          bt.data = tclamp(v, (p < 2) ? SW : SH);
        end
        exp_q.push_back(bt);
      end
    end
  endtask

  // Expected stream straight from the hand-computed table rows.
  task automatic use_table(input int f);
    beat_t bt;
    row_t  rw;
    for (int i = 0; i < RC; i++) cur[i] = tbl[f*RC + i].r;
    load_mem();
    exp_q.delete();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < RC; i++) begin
        rw = tbl[f*RC + i];
        bt.field = 3'(p);
        bt.last  = ((i % BS) == BS - 1);
        case (p)
          0:       bt.data = rw.l;
          1:       bt.data = rw.rt;
          2:       bt.data = rw.t;
          3:       bt.data = rw.b;
          default: bt.data = rw.r.col;
        endcase
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_addr",  32'(mem_din_addr), 32'(RA));
    chk("rst_data",  32'(out_data), 32'd0);
    chk("rst_field", 32'(out_field), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
  endtask

  task automatic start_frame();
    copy_start = 1'b1;
    tick();
    copy_start = 1'b0;
    chk("start_addr", 32'(mem_din_addr), 32'(RA));
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Drives ready / batch-done and scores beats until done. With stop_field
  // >= 0 it returns as soon as a beat of that field is offered.
  task automatic run_loop(input int first, input int stop_field, input bit noisy);
    int beats, pend, cyc, fin;
    beats = first; pend = 0; cyc = 0; fin = -10;
    while (!done) begin
      if (cyc >= 3000) begin
        fail_now("frame_timeout");
        return;
      end
      if (stop_field >= 0 && out_valid && out_field == 3'(stop_field)) begin
        out_ready = 1'b0; gpu_batch_done = 1'b0; copy_start = 1'b0;
        return;
      end
      if (pend > 0) chk("valid_in_wait", 32'(out_valid), 32'd0);
      gpu_batch_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          gpu_batch_done = 1'b1;
          if (beats == exp_q.size()) fin = cyc;
        end
      end else if (noisy) begin
        gpu_batch_done = ($urandom_range(0, 7) == 0);
      end
      out_ready  = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
      copy_start = noisy && ($urandom_range(0, 15) == 0);
      if (out_valid && out_ready) begin
        if (beats < exp_q.size()) begin
          chk($sformatf("beat%0d_field", beats), 32'(out_field), 32'(exp_q[beats].field));
          chk($sformatf("beat%0d_data", beats),  32'(out_data),  32'(exp_q[beats].data));
          chk($sformatf("beat%0d_last", beats),  32'(out_last),  32'(exp_q[beats].last));
        end else begin
          chk("extra_beat", 32'(beats), 32'(exp_q.size() - 1));
        end
        if (out_last) pend = noisy ? $urandom_range(1, 12) : 1;
        beats++;
      end
      tick();
      cyc++;
    end
    gpu_batch_done = 1'b0;
    chk("beat_count", 32'(beats), 32'(exp_q.size()));
    chk("done_latency", 32'(cyc), 32'(fin + 1));
    chk("busy_at_done", 32'(busy), 32'd0);
    // a start coinciding with done must be ignored
    copy_start = 1'b1;
    tick();
    copy_start = 1'b0;
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("start_on_done_ignored", 32'(busy), 32'd0);
  endtask

  function automatic logic [15:0] rw16();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 1100));
      1:       return 16'(16'd0 - 16'($urandom_range(0, 200)));
      2:       return 16'($urandom);
      default: return 16'(16'h7F00 + 16'($urandom_range(0, 255)));
    endcase
  endfunction

  initial begin
    // {record, expected LEFT, RIGHT, TOP, BOTTOM}; colour passes through
    tbl[0]  = mkrow(mk(16'h0001, 16'd600,  16'd100,  16'd100,  16'd50,  16'h1111), 16'd600, 16'd640, 16'd100, 16'd150);
    tbl[1]  = mkrow(mk(16'h0000, 16'hFD44, 16'd10,   16'd50,   16'd20,  16'h2222), 16'd0,   16'd0,   16'd110, 16'd130);
    tbl[2]  = mkrow(mk(16'h0001, 16'h7FF0, 16'hFFFB, 16'h0020, 16'd3,   16'h3333), 16'd640, 16'd0,   16'd0,   16'd0);
    tbl[3]  = mkrow(mk(16'h0000, 16'd5,    16'd20,   16'd1,    16'd1,   16'hF00F), 16'd640, 16'd640, 16'd15,  16'd16);
    tbl[4]  = mkrow(mk(16'h0001, 16'd100,  16'd50,   16'd40,   16'd30,  16'hF00F), 16'd100, 16'd140, 16'd50,  16'd80);
    tbl[5]  = mkrow(mk(16'h0000, 16'd0,    16'd0,    16'd0,    16'd0,   16'h0001), 16'd100, 16'd100, 16'd50,  16'd50);
    tbl[6]  = mkrow(mk(16'h0003, 16'd639,  16'd479,  16'd1,    16'd1,   16'h8000), 16'd639, 16'd640, 16'd479, 16'd480);
    tbl[7]  = mkrow(mk(16'hFFFF, 16'd0,    16'd0,    16'd640,  16'd480, 16'hFFFF), 16'd0,   16'd640, 16'd0,   16'd480);
    tbl[8]  = mkrow(mk(16'h0000, 16'd10,   16'd20,   16'd5,    16'd5,   16'hAAAA), 16'd10,  16'd15,  16'd20,  16'd25);
    tbl[9]  = mkrow(mk(16'hFFFE, 16'd30,   16'd40,   16'd10,   16'd10,  16'h5555), 16'd30,  16'd40,  16'd40,  16'd50);
    tbl[10] = mkrow(mk(16'h0001, 16'd200,  16'd300,  16'hFFF6, 16'd200, 16'h0F0F), 16'd200, 16'd190, 16'd300, 16'd480);
    tbl[11] = mkrow(mk(16'h0000, 16'hFFCE, 16'hFF38, 16'd100,  16'd100, 16'h1234), 16'd150, 16'd250, 16'd100, 16'd200);

    for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
    reset = 1'b1; copy_start = 1'b0; out_ready = 1'b0; gpu_batch_done = 1'b0;
    tick(); tick(); tick();
    check_reset_vals();
    reset = 1'b0;
    tick();

    // start latency, first beat timing, backpressure with a stray batch-done
    use_table(1);
    out_ready = 1'b0;
    start_frame();
    tick();
    chk("coord_addr", 32'(mem_din_addr), 32'(RA) + 32'd1);
    tick();
    chk("calc_no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'(exp_q[0].data));
    for (int k = 0; k < 7; k++) begin
      gpu_batch_done = (k == 3);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data), 32'(exp_q[0].data));
      chk("bp_field", 32'(out_field), 32'd0);
      chk("bp_last",  32'(out_last), 32'd0);
    end
    gpu_batch_done = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("accepted_once", 32'(out_valid), 32'd0);
    chk("next_rect_addr", 32'(mem_din_addr), 32'(RA) + 32'd6);
    run_loop(1, -1, 1'b0);
    $display("frame backpressure beats=%0d total=%0d", exp_q.size(), total);

    // table-driven frames
    for (int f = 0; f < 3; f++) begin
      use_table(f);
      start_frame();
      run_loop(0, -1, 1'b0);
      $display("frame table%0d beats=%0d total=%0d", f, exp_q.size(), total);
    end

    // reset in the middle of the RIGHT pass, then a clean restart
    use_table(2);
    start_frame();
    run_loop(0, 1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals();
    tick();
    start_frame();
    run_loop(0, -1, 1'b1);
    $display("frame reset_restart beats=%0d total=%0d", exp_q.size(), total);

    // randomized frames against the reference model
    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < RC; i++)
        cur[i] = mk(16'($urandom), rw16(), rw16(), rw16(), rw16(), 16'($urandom));
      load_mem();
      build_model();
      start_frame();
      run_loop(0, -1, 1'b1);
      $display("frame random%0d beats=%0d total=%0d", f, exp_q.size(), total);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
